uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line input plus the received-byte and status strobes.
interface uart_rx_if;
  logic       rx;
  logic [7:0] outDato;
  logic       outValid;
  logic       outFrameErr;
  logic       outBusy;

  // Line driver / byte consumer side
  modport master (
    output rx,
    input  outDato,
    input  outValid,
    input  outFrameErr,
    input  outBusy
  );

  // Receiver side
  modport slave (
    input  rx,
    output outDato,
    output outValid,
    output outFrameErr,
    output outBusy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling. The start edge realigns the tick
// phase; mid-bit samples drive a small framing FSM. Good frames update the
// output byte with a one-clock strobe, a low stop bit gives one frame-error
// strobe and then waits for the line to return high (one error per break).
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int OVERSAMPLE = 16;
  localparam int TICK_RAW   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TICK_DIV   = (TICK_RAW < 2) ? 2 : TICK_RAW;
  localparam int TW         = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]      samp_q, samp_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      dato_q, dato_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;
  logic            rx_s;
  logic            tick;

  assign rx_s = sync2_q;
  assign tick = (tick_cnt_q == TICK_LAST);

  // Two-flop synchronizer for the asynchronous line; resets to idle-high
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
    end
  end

  // Framing state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter updates, shift/capture and strobes
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    samp_d     = tick ? samp_q + 1'b1 : samp_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    dato_d     = dato_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          samp_d     = '0;
        end
      end

      S_START: begin
        if (tick && (samp_q == 4'd7)) begin
          if (!rx_s) begin
            state_d = S_DATA;
            samp_d  = '0;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (tick && (samp_q == 4'd15)) begin
          shift_d[bit_q] = rx_s;
          bit_d          = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            samp_d  = '0;
          end
        end
      end

      S_STOP: begin
        if (tick && (samp_q == 4'd15)) begin
          if (rx_s) begin
            dato_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK_WAIT;
          end
        end
      end

      S_BREAK_WAIT: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      samp_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      dato_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      dato_q     <= dato_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.outDato     = dato_q;
  assign bus.outValid    = valid_q;
  assign bus.outFrameErr = ferr_q;
  assign bus.outBusy     = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: scenario tasks plus a randomized frame stream
// checked against a byte-level reference (queue of expected bytes).
module tb_uart_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int TICK_DIV = 10;
  localparam int BIT_CLKS = 160;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_if u_if ();

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if.slave)
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  int unsigned cyc    = 0;
  logic        rst_seen = 1'b1;

  // Monitor state
  logic [7:0]  got_q[$];
  int          ferr_cnt  = 0;
  int          both_cnt  = 0;
  int          hold_err  = 0;
  int unsigned valid_cyc = 0;
  logic [7:0]  prev_dato = 8'h00;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  always @(negedge clk) begin
    if (u_if.outValid === 1'b1) begin
      got_q.push_back(u_if.outDato);
      valid_cyc = cyc;
    end
    if (u_if.outFrameErr === 1'b1) ferr_cnt++;
    if (u_if.outValid === 1'b1 && u_if.outFrameErr === 1'b1) both_cnt++;
    if (!rst_seen && u_if.outValid !== 1'b1 && u_if.outDato !== prev_dato) hold_err++;
    prev_dato = u_if.outDato;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame starting at the current negedge. rst_bit >= 0 pulses
  // reset for one clock in the middle of that data bit. low_hold keeps the
  // line low after the stop bit for that many clocks.
  task automatic send_frame(input logic [7:0] b, input int blen, input logic stop_bit,
                            input int rst_bit, input int low_hold,
                            output int unsigned edge_cyc);
    u_if.rx  = 1'b0;
    edge_cyc = cyc;
    idle(blen);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i];
      if (i == rst_bit) begin
        idle(blen / 2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(blen - blen / 2 - 1);
      end else begin
        idle(blen);
      end
    end
    u_if.rx = stop_bit;
    idle(blen);
    if (low_hold > 0) begin
      u_if.rx = 1'b0;
      idle(low_hold);
    end
    u_if.rx = 1'b1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    u_if.rx = 1'b1;
    idle(4);
    n_vec++; if (u_if.outDato !== 8'h00) begin n_fail++; $display("FAIL reset_dato: got %h expected 00", u_if.outDato); end
    n_vec++; if (u_if.outValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", u_if.outValid); end
    n_vec++; if (u_if.outFrameErr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", u_if.outFrameErr); end
    n_vec++; if (u_if.outBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", u_if.outBusy); end
    reset = 1'b0;
    idle(20);
    n_vec++; if (u_if.outBusy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", u_if.outBusy); end
  endtask

  task automatic test_single();
    int unsigned e;
    int          f0;
    int          lat;
    got_q.delete();
    f0 = ferr_cnt;
    send_frame(8'h73, BIT_CLKS, 1'b1, -1, 0, e);
    idle(BIT_CLKS);
    lat = int'(valid_cyc) - int'(e) - (BIT_CLKS * 9 + BIT_CLKS / 2);
    n_vec++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
    n_vec++; if (got_q.size() == 1 && got_q[0] !== 8'h73) begin n_fail++; $display("FAIL single_byte: got %h expected 73", got_q[0]); end
    n_vec++; if (u_if.outDato !== 8'h73) begin n_fail++; $display("FAIL single_dato: got %h expected 73", u_if.outDato); end
    n_vec++; if (ferr_cnt !== f0) begin n_fail++; $display("FAIL single_ferr: got %0d expected %0d", ferr_cnt, f0); end
    n_vec++; if (u_if.outBusy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", u_if.outBusy); end
    n_vec++; if (lat < 0 || lat > TICK_DIV + 2) begin n_fail++; $display("FAIL single_latency: got %0d expected 0..%0d", lat, TICK_DIV + 2); end
  endtask

  task automatic test_glitch();
    int f0;
    got_q.delete();
    f0 = ferr_cnt;
    u_if.rx = 1'b0;
    idle(40);
    u_if.rx = 1'b1;
    idle(2 * BIT_CLKS);
    n_vec++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 0", got_q.size()); end
    n_vec++; if (ferr_cnt !== f0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected %0d", ferr_cnt, f0); end
    n_vec++; if (u_if.outBusy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b expected 0", u_if.outBusy); end
    n_vec++; if (u_if.outDato !== 8'h73) begin n_fail++; $display("FAIL glitch_dato: got %h expected 73", u_if.outDato); end
  endtask

  task automatic test_back_to_back();
    int unsigned e;
    got_q.delete();
    send_frame(8'hA5, BIT_CLKS, 1'b1, -1, 0, e);
    send_frame(8'h00, BIT_CLKS, 1'b1, -1, 0, e);
    idle(BIT_CLKS);
    n_vec++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", got_q.size()); end
    n_vec++; if (got_q.size() >= 1 && got_q[0] !== 8'hA5) begin n_fail++; $display("FAIL b2b_first: got %h expected a5", got_q[0]); end
    n_vec++; if (got_q.size() >= 2 && got_q[1] !== 8'h00) begin n_fail++; $display("FAIL b2b_second: got %h expected 00", got_q[1]); end
    n_vec++; if (u_if.outDato !== 8'h00) begin n_fail++; $display("FAIL b2b_dato: got %h expected 00", u_if.outDato); end
  endtask

  task automatic test_break();
    int unsigned e;
    int          f0;
    got_q.delete();
    f0 = ferr_cnt;
    send_frame(8'h55, BIT_CLKS, 1'b0, -1, 3 * BIT_CLKS, e);
    idle(2 * BIT_CLKS);
    n_vec++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL break_ferr: got %0d expected 1", ferr_cnt - f0); end
    n_vec++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL break_valid: got %0d expected 0", got_q.size()); end
    n_vec++; if (u_if.outDato !== 8'h00) begin n_fail++; $display("FAIL break_dato: got %h expected 00", u_if.outDato); end
    n_vec++; if (u_if.outBusy !== 1'b0) begin n_fail++; $display("FAIL break_busy: got %b expected 0", u_if.outBusy); end
    send_frame(8'h31, BIT_CLKS, 1'b1, -1, 0, e);
    idle(BIT_CLKS);
    n_vec++; if (got_q.size() !== 1 || u_if.outDato !== 8'h31) begin n_fail++; $display("FAIL break_next: got %h (count %0d) expected 31 (count 1)", u_if.outDato, got_q.size()); end
  endtask

  task automatic test_reset_midframe();
    int unsigned e;
    int          f0;
    got_q.delete();
    f0 = ferr_cnt;
    send_frame(8'hFF, BIT_CLKS, 1'b1, 4, 0, e);
    idle(2 * BIT_CLKS);
    n_vec++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_valid: got %0d expected 0", got_q.size()); end
    n_vec++; if (ferr_cnt !== f0) begin n_fail++; $display("FAIL rstmid_ferr: got %0d expected %0d", ferr_cnt, f0); end
    n_vec++; if (u_if.outDato !== 8'h00) begin n_fail++; $display("FAIL rstmid_dato: got %h expected 00", u_if.outDato); end
    n_vec++; if (u_if.outBusy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", u_if.outBusy); end
    send_frame(8'h73, BIT_CLKS, 1'b1, -1, 0, e);
    idle(BIT_CLKS);
    n_vec++; if (got_q.size() !== 1 || u_if.outDato !== 8'h73) begin n_fail++; $display("FAIL rstmid_next: got %h (count %0d) expected 73 (count 1)", u_if.outDato, got_q.size()); end
  endtask

  task automatic test_skew();
    int unsigned e;
    int          blen;
    for (int k = 0; k < 2; k++) begin
      blen = (k == 0) ? 155 : 165;
      got_q.delete();
      send_frame(8'h73, blen, 1'b1, -1, 0, e);
      idle(BIT_CLKS);
      n_vec++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL skew%0d_count: got %0d expected 1", blen, got_q.size()); end
      n_vec++; if (got_q.size() == 1 && got_q[0] !== 8'h73) begin n_fail++; $display("FAIL skew%0d_byte: got %h expected 73", blen, got_q[0]); end
    end
  endtask

  // Reference: a frame with a high stop bit yields exactly its byte, in order;
  // a low stop bit yields one frame error and leaves the output byte alone.
  task automatic test_random();
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    logic [7:0]  last;
    int unsigned e;
    int          blen, gap, hold, f0, exp_ferr;
    logic        good;
    got_q.delete();
    f0       = ferr_cnt;
    exp_ferr = 0;
    last     = u_if.outDato;
    for (int k = 0; k < 22; k++) begin
      b    = 8'($urandom);
      blen = int'($urandom_range(165, 155));
      good = ($urandom_range(4, 0) != 0);
      if (good) begin
        exp_q.push_back(b);
        last = b;
        hold = 0;
        gap  = int'($urandom_range(60, 0));
      end else begin
        exp_ferr++;
        hold = int'($urandom_range(300, 0));
        gap  = int'($urandom_range(80, 20));
      end
      send_frame(b, blen, good, -1, hold, e);
      idle(gap);
    end
    idle(2 * BIT_CLKS);
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (ferr_cnt - f0 !== exp_ferr) begin n_fail++; $display("FAIL rand_ferr: got %0d expected %0d", ferr_cnt - f0, exp_ferr); end
    n_vec++; if (u_if.outDato !== last) begin n_fail++; $display("FAIL rand_dato: got %h expected %h", u_if.outDato, last); end
    n_vec++; if (both_cnt !== 0) begin n_fail++; $display("FAIL both_strobes: got %0d expected 0", both_cnt); end
    n_vec++; if (hold_err !== 0) begin n_fail++; $display("FAIL dato_hold: got %0d expected 0", hold_err); end
  endtask

  initial begin
    reset   = 1'b1;
    u_if.rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_glitch();
    test_back_to_back();
    test_break();
    test_reset_midframe();
    test_skew();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
